way_fill_writer: RTL and testbench

//  Write-side counterpart of the cache read-path way-select mux. Collects a cache line

---
 rtl/way_fill_writer_if.sv | 28 ++
 rtl/way_fill_writer.sv | 104 ++++++++++
 tb/tb_way_fill_writer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/way_fill_writer_if.sv
// Refill-side handshake and data-array write bundle for way_fill_writer.
// The slave modport is the block's view; the master modport is the refill/array side.
interface way_fill_writer_if #(
    parameter int unsigned LINE_SIZE_BYTES = 64,
    parameter int unsigned WAYS            = 4,
    parameter int unsigned BEAT_BYTES      = 8
);
    logic                         i_fill_start;
    logic [WAYS-1:0]              i_way_sel;
    logic                         i_beat_valid;
    logic [BEAT_BYTES*8-1:0]      i_beat_data;
    logic                         o_beat_ready;
    logic [WAYS-1:0]              o_wr_en;
    logic [LINE_SIZE_BYTES*8-1:0] o_wr_data;
    logic                         o_busy;
    logic                         o_done;
    logic                         o_err;

    modport slave (
        input  i_fill_start, i_way_sel, i_beat_valid, i_beat_data,
        output o_beat_ready, o_wr_en, o_wr_data, o_busy, o_done, o_err
    );

    modport master (
        output i_fill_start, i_way_sel, i_beat_valid, i_beat_data,
        input  o_beat_ready, o_wr_en, o_wr_data, o_busy, o_done, o_err
    );
endinterface

// File: rtl/way_fill_writer.sv
// Assembles a refill line from fixed-width beats, then issues a one-cycle one-hot
// per-way write strobe carrying the whole line to the data arrays.
module way_fill_writer #(
    parameter int unsigned LINE_SIZE_BYTES = 64,
    parameter int unsigned WAYS            = 4,
    parameter int unsigned BEAT_BYTES      = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    way_fill_writer_if.slave    fill_if
);
    localparam int unsigned BEATS  = LINE_SIZE_BYTES / BEAT_BYTES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BEAT_W = BEAT_BYTES * 8;
    localparam int unsigned LINE_W = LINE_SIZE_BYTES * 8;

    typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WAYS-1:0]    r_sel;
    logic [LINE_W-1:0]  r_line;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [WAYS-1:0]    r_wr_en;

    logic w_accept;
    logic w_last;
    logic w_sel_ok;

    function automatic logic is_onehot(input logic [WAYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    assign w_accept = r_ready & fill_if.i_beat_valid;
    assign w_last   = (r_cnt == CNT_W'(BEATS - 1));
    assign w_sel_ok = is_onehot(fill_if.i_way_sel);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_line  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wr_en <= '0;
        end else begin
            // Pulse outputs default low; only the transitions below raise them.
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wr_en <= '0;
            case (r_state)
                StIdle: begin
                    if (fill_if.i_fill_start) begin
                        if (w_sel_ok) begin
                            r_sel   <= fill_if.i_way_sel;
                            r_cnt   <= '0;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= StCollect;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StCollect: begin
                    if (w_accept) begin
                        r_line[r_cnt*BEAT_W +: BEAT_W] <= fill_if.i_beat_data;
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_ready <= 1'b0;
                            r_wr_en <= r_sel;
                            r_done  <= 1'b1;
                            r_state <= StWrite;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                StWrite: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign fill_if.o_beat_ready = r_ready;
    assign fill_if.o_wr_en      = r_wr_en;
    assign fill_if.o_wr_data    = r_line;
    assign fill_if.o_busy       = r_busy;
    assign fill_if.o_done       = r_done;
    assign fill_if.o_err        = r_err;
endmodule

// File: tb/tb_way_fill_writer.sv
// Randomised scoreboard bench for way_fill_writer: the driver predicts each line write
// and rejected start; a negedge monitor pops and compares whenever the block reports one.
module tb_way_fill_writer;
    localparam int unsigned LSB   = 64;
    localparam int unsigned WAYS  = 4;
    localparam int unsigned BB    = 8;
    localparam int unsigned BEATS = LSB / BB;
    localparam int unsigned BW    = BB * 8;
    localparam int unsigned LW    = LSB * 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    way_fill_writer_if #(.LINE_SIZE_BYTES(LSB), .WAYS(WAYS), .BEAT_BYTES(BB)) bus ();

    way_fill_writer #(.LINE_SIZE_BYTES(LSB), .WAYS(WAYS), .BEAT_BYTES(BB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .fill_if (bus)
    );

    typedef struct {
        logic [WAYS-1:0] way;
        logic [LW-1:0]   line;
        int unsigned     cyc;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned err_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    wr_t         mon_e;
    int unsigned mon_ec;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_wr_en != '0 || bus.o_done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: wr_en %b done %b, nothing pending (cycle %0d)",
                             bus.o_wr_en, bus.o_done, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_en", bus.o_wr_en, mon_e.way);
                    chk("done", bus.o_done, 1'b1);
                    chk("wr_data", bus.o_wr_data, mon_e.line);
                    chk("wr_cycle", cyc, mon_e.cyc);
                end
            end
            if (bus.o_err) begin
                if (err_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_err: got 1 want 0 (cycle %0d)", cyc);
                end else begin
                    mon_ec = err_q.pop_front();
                    chk("err_cycle", cyc, mon_ec);
                    chk("err_busy", bus.o_busy, 1'b0);
                end
            end
        end
    end

    task automatic chk_quiet(input string name);
        chk({name, "_ready"}, bus.o_beat_ready, 1'b0);
        chk({name, "_busy"}, bus.o_busy, 1'b0);
        chk({name, "_wr_en"}, bus.o_wr_en, '0);
        chk({name, "_done"}, bus.o_done, 1'b0);
        chk({name, "_err"}, bus.o_err, 1'b0);
    endtask

    // Called at a negedge with the block idle. abort_after < 0 runs a full line.
    task automatic do_fill(input logic [WAYS-1:0] way, input bit gaps, input bit hold,
                           input bit pattern, input int abort_after);
        int unsigned    start_c;
        logic [LW-1:0]  line;
        logic [BW-1:0]  d;
        int             k;
        int             budget;
        bit             tog;
        wr_t            e;
        start_c          = cyc;
        bus.i_fill_start = 1'b1;
        bus.i_way_sel    = way;
        bus.i_beat_valid = 1'($urandom_range(0, 1));
        bus.i_beat_data  = {$urandom, $urandom};
        @(negedge clk);
        chk("collect_ready", bus.o_beat_ready, 1'b1);
        chk("collect_busy", bus.o_busy, 1'b1);
        if (!hold) bus.i_fill_start = 1'b0;
        line   = '0;
        k      = 0;
        budget = 0;
        tog    = 1'b0;
        while (k < int'(BEATS) && k != abort_after) begin
            if (hold) begin
                bus.i_fill_start = 1'b1;
                bus.i_way_sel    = WAYS'($urandom);
            end
            tog              = ~tog;
            bus.i_beat_valid = gaps ? tog : 1'b1;
            d                = pattern ? {8{8'(k)}} : {$urandom, $urandom};
            bus.i_beat_data  = d;
            if (bus.i_beat_valid && bus.o_beat_ready) begin
                line[k*BW +: BW] = d;
                if (k == int'(BEATS) - 1) begin
                    e.way  = way;
                    e.line = line;
                    e.cyc  = gaps ? cyc + 1 : start_c + 1 + BEATS;
                    exp_q.push_back(e);
                end
                k++;
            end
            @(negedge clk);
            budget++;
            if (budget > int'(4 * BEATS + 8)) begin
                vectors++;
                miscompares++;
                $display("FAIL fill_timeout: got %0d beats want %0d", k, BEATS);
                break;
            end
        end
        bus.i_beat_valid = 1'b0;
        // Step over the WRITE cycle so the next start lands in IDLE.
        if (k == int'(BEATS)) @(negedge clk);
    endtask

    task automatic do_bad(input logic [WAYS-1:0] way);
        bus.i_fill_start = 1'b1;
        bus.i_way_sel    = way;
        err_q.push_back(cyc + 1);
        @(negedge clk);
        bus.i_fill_start = 1'b0;
        chk("bad_busy", bus.o_busy, 1'b0);
        chk("bad_ready", bus.o_beat_ready, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_beat_valid = 1'($urandom_range(0, 1));
            bus.i_beat_data  = {$urandom, $urandom};
            @(negedge clk);
            chk("idle_ready", bus.o_beat_ready, 1'b0);
        end
        bus.i_beat_valid = 1'b0;
    endtask

    function automatic logic [WAYS-1:0] rand_onehot();
        return WAYS'(1) << $urandom_range(0, WAYS - 1);
    endfunction

    function automatic logic [WAYS-1:0] rand_bad();
        logic [WAYS-1:0] w;
        do w = WAYS'($urandom); while ($countones(w) == 1);
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_fill_start = 1'b0;
        bus.i_way_sel    = '0;
        bus.i_beat_valid = 1'b0;
        bus.i_beat_data  = '0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_wr_data", bus.o_wr_data, '0);
        rst_n = 1'b1;

        // Beats offered while idle must be refused and never land in the line.
        for (int i = 0; i < 4; i++) begin
            bus.i_beat_valid = 1'b1;
            bus.i_beat_data  = {$urandom, $urandom};
            @(negedge clk);
            chk_quiet("idle");
            chk("idle_wr_data", bus.o_wr_data, '0);
        end
        bus.i_beat_valid = 1'b0;

        do_fill(4'b0100, 1'b0, 1'b0, 1'b1, -1);
        do_fill(4'b0001, 1'b1, 1'b0, 1'b1, -1);

        do_bad(4'b0110);
        do_bad(4'b0000);
        idle_cycles(2);

        // Reset mid-fill: outputs clear at once and the next fill starts clean.
        do_fill(4'b0010, 1'b0, 1'b0, 1'b0, 5);
        #2 rst_n = 1'b0;
        #1;
        chk_quiet("midfill_reset");
        chk("midfill_reset_wr_data", bus.o_wr_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_fill(4'b1000, 1'b0, 1'b0, 1'b0, -1);

        // Start held through COLLECT/WRITE with noise on the select, then an immediate refill.
        do_fill(4'b0010, 1'b0, 1'b1, 1'b0, -1);
        do_fill(4'b0100, 1'b0, 1'b0, 1'b0, -1);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       do_bad(rand_bad());
                1:       idle_cycles($urandom_range(1, 3));
                default: do_fill(rand_onehot(), 1'($urandom_range(0, 1)),
                                 1'($urandom_range(0, 1)), 1'b0, -1);
            endcase
            bus.i_fill_start = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);
        chk("pending_errs", err_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
